regfile_reader: RTL and testbench
=================================

REGFILE_READER -- requirements
Module: regfile_reader

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  operand-fetch request present
- req_ready  out  1  block accepts request
- req_a  in  5  register index, operand A
- req_b  in  5  register index, operand B
- arr_addr  out  5  read index to register array
- arr_data  in  32  array read data, combinational from arr_addr, pre-write contents
- set  in  1  array write strobe (snooped; array updates at end of cycle)
- wr_addr  in  5  array write index
- in  in  32  array write data
- rsp_valid  out  1  operands available
- rsp_ready  in  1  consumer takes operands
- out_a  out  32  operand A value
- out_b  out  32  operand B value

Function
REQ-003 The block SHALL implement the FSM states IDLE, READ_A, READ_B and RESP.
REQ-004 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-005 In IDLE, when req_valid=1, the block SHALL latch req_a/req_b and go to READ_A.
REQ-006 In READ_A, arr_addr SHALL equal the latched A index; the A slot SHALL capture the operand; next state READ_B.
REQ-007 In READ_B, arr_addr SHALL equal the latched B index; the B slot SHALL capture the operand; next state RESP.
REQ-008 In IDLE and RESP, arr_addr SHALL be 0.
REQ-009 Capture value, in priority order:
- index 0 gives 0;
- otherwise, set=1 with wr_addr equal to the index gives in (write forwarding);
- otherwise arr_data.
REQ-010 After a slot has captured, any later cycle with set=1 and wr_addr equal to that slot's nonzero index SHALL overwrite the slot with in, until the RESP handshake cycle (exclusive).
REQ-011 In the RESP handshake cycle (rsp_valid and rsp_ready both 1), set SHALL NOT modify the slots.
REQ-012 out_a/out_b SHALL be registered slot contents; a write forwarded in cycle N SHALL be visible on out_x in cycle N+1.
REQ-013 rsp_valid SHALL be 1 exactly in RESP; out_a/out_b SHALL be stable while rsp_valid=1 and rsp_ready=0, except for REQ-010 updates.
REQ-014 In RESP with rsp_ready=1, the block SHALL go to IDLE; the next request can be accepted in the following cycle.
REQ-015 Latency: request accepted in cycle 0 gives rsp_valid=1 in cycle 3; minimum request spacing SHALL be 4 cycles.
REQ-016 req_a equal to req_b SHALL be legal; both reads SHALL still be performed and both slots captured independently.
REQ-017 Writes to index 0 SHALL never be forwarded; out_x for index 0 SHALL be 0.

Reset
REQ-018 On reset=1 at a clock edge, the block SHALL enter IDLE with rsp_valid=0, out_a=0, out_b=0 and latched indices 0, regardless of current state.
REQ-019 A request in flight when reset asserts SHALL be discarded with no response.
REQ-020 While reset=1, req_ready SHALL be 0; it SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-021 Package regfile_pkg SHALL hold REG_W=32, ADDR_W=5, NUM_REGS=32 and the FSM state enum; the block SHALL import it.
REQ-022 Capture/forward/hold logic SHALL be one sub-module, operand_slot, instantiated twice (A, B).
REQ-023 The block SHALL contain no storage array; array content is external.

Verification
REQ-024 Array r3=0x11111111, r7=0x22222222; request a=3, b=7 -> cycle 1 arr_addr=3, cycle 2 arr_addr=7, cycle 3 rsp_valid=1, out_a=0x11111111, out_b=0x22222222.
REQ-025 Request a=0, b=0 with array r0 content 0xDEADBEEF -> out_a=out_b=0.
REQ-026 Request a=5, b=5, array r5=0xAAAA0000; set=1, wr_addr=5, in=0x0000BBBB during READ_A -> out_a=out_b=0x0000BBBB.
REQ-027 Response held with rsp_ready=0 for 5 cycles; write r3=0x33333333 in the 2nd held cycle -> out_a=0x33333333 from the next cycle; write in the handshake cycle -> not reflected; req_ready=1 the next cycle.
REQ-028 Reset asserted in READ_B -> next cycle IDLE, rsp_valid=0, out_a=out_b=0, no response ever issued for that request.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and FSM state encoding for the register-file operand reader.
package regfile_pkg;

   localparam int unsigned REG_W    = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_REGS = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ_A = 2'd1,
      READ_B = 2'd2,
      RESP   = 2'd3
   } state_t;

endpackage

// File: rtl/regfile_reader_operand_slot.sv
// One operand register: captures a read (with write forwarding), then tracks
// later writes to its index until the response handshake.
module operand_slot
   import regfile_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              capture,
   input  logic              done,
   input  logic [ADDR_W-1:0] idx,
   input  logic [REG_W-1:0]  arr_data,
   input  logic              set,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [REG_W-1:0]  in,
   output logic [REG_W-1:0]  value
);

   logic held;
   logic hit;

   // Register 0 is hardwired to zero, so writes to it never match.
   assign hit = set && (wr_addr == idx) && (idx != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         value <= '0;
         held  <= 1'b0;
      end else if (capture) begin
         if (idx == '0)
            value <= '0;
         else if (hit)
            value <= in;
         else
            value <= arr_data;
         held <= 1'b1;
      end else if (done) begin
         held <= 1'b0;
      end else if (held && hit) begin
         value <= in;
      end
   end

endmodule

// File: rtl/regfile_reader.sv
// Two-operand fetch from an external register array: reads A then B through a
// single read port and presents both operands with a valid/ready handshake.
module regfile_reader
   import regfile_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_a,
   input  logic [ADDR_W-1:0] req_b,
   output logic [ADDR_W-1:0] arr_addr,
   input  logic [REG_W-1:0]  arr_data,
   input  logic              set,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [REG_W-1:0]  in,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [REG_W-1:0]  out_a,
   output logic [REG_W-1:0]  out_b
);

   state_t            state;
   logic [ADDR_W-1:0] idx_a;
   logic [ADDR_W-1:0] idx_b;
   logic              handshake;

   assign req_ready = (state == IDLE) && !reset;
   assign rsp_valid = (state == RESP);
   assign handshake = rsp_valid && rsp_ready;

   always_comb begin
      arr_addr = '0;
      case (state)
         READ_A:  arr_addr = idx_a;
         READ_B:  arr_addr = idx_b;
         default: arr_addr = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         idx_a <= '0;
         idx_b <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               idx_a <= req_a;
               idx_b <= req_b;
               state <= READ_A;
            end
            READ_A:  state <= READ_B;
            READ_B:  state <= RESP;
            RESP:    if (rsp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   operand_slot u_slot_a (
      .clk      (clk),
      .reset    (reset),
      .capture  (state == READ_A),
      .done     (handshake),
      .idx      (idx_a),
      .arr_data (arr_data),
      .set      (set),
      .wr_addr  (wr_addr),
      .in       (in),
      .value    (out_a)
   );

   operand_slot u_slot_b (
      .clk      (clk),
      .reset    (reset),
      .capture  (state == READ_B),
      .done     (handshake),
      .idx      (idx_b),
      .arr_data (arr_data),
      .set      (set),
      .wr_addr  (wr_addr),
      .in       (in),
      .value    (out_b)
   );

endmodule

// File: tb/tb_regfile_reader.sv
// Scoreboard bench: accepted requests are queued; a negedge monitor checks the
// read sequence, latency and operand values against a register-array model.
module tb_regfile_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_a;
   logic [4:0]  req_b;
   logic [4:0]  arr_addr;
   logic [31:0] arr_data;
   logic        set;
   logic [4:0]  wr_addr;
   logic [31:0] in;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] out_a;
   logic [31:0] out_b;

   logic [31:0] mem [32];

   typedef struct {
      logic [4:0] a;
      logic [4:0] b;
      int         acc;
   } txn_t;

   txn_t pend[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   logic prev_reset = 1'b0;

   always #5 clk = ~clk;

   regfile_reader dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .arr_addr  (arr_addr),
      .arr_data  (arr_data),
      .set       (set),
      .wr_addr   (wr_addr),
      .in        (in),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .out_a     (out_a),
      .out_b     (out_b)
   );

   // External register array: combinational read, write at end of cycle.
   assign arr_data = mem[arr_addr];
   always @(posedge clk) if (set) mem[wr_addr] <= in;

   // Architectural register value: r0 reads as zero whatever the array holds.
   function automatic logic [31:0] reg_val(input logic [4:0] idx);
      return (idx == 5'd0) ? 32'd0 : mem[idx];
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   always @(negedge clk) begin
      int age;
      cyc++;
      if (prev_reset) begin
         chk("post_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
         chk("post_reset_out_a", out_a, 32'd0);
         chk("post_reset_out_b", out_b, 32'd0);
      end
      if (reset) begin
         chk("ready_in_reset", {31'd0, req_ready}, 32'd0);
         pend.delete();
      end else if (pend.size() != 0) begin
         age = cyc - pend[0].acc;
         chk("busy_req_ready", {31'd0, req_ready}, 32'd0);
         if (age == 1) begin
            chk("read_a_addr", {27'd0, arr_addr}, {27'd0, pend[0].a});
            chk("read_a_rsp_valid", {31'd0, rsp_valid}, 32'd0);
         end else if (age == 2) begin
            chk("read_b_addr", {27'd0, arr_addr}, {27'd0, pend[0].b});
            chk("read_b_rsp_valid", {31'd0, rsp_valid}, 32'd0);
         end else begin
            chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("resp_addr", {27'd0, arr_addr}, 32'd0);
            chk("resp_out_a", out_a, reg_val(pend[0].a));
            chk("resp_out_b", out_b, reg_val(pend[0].b));
            if (rsp_ready) void'(pend.pop_front());
         end
      end else begin
         chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
         chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
         chk("idle_addr", {27'd0, arr_addr}, 32'd0);
         if (req_valid) pend.push_back('{a: req_a, b: req_b, acc: cyc});
      end
      prev_reset = reset;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      set = 1'b1; wr_addr = a; in = d;
      step();
      set = 1'b0;
   endtask

   task automatic issue(input logic [4:0] a, input logic [4:0] b);
      req_valid = 1'b1; req_a = a; req_b = b;
      step();
      req_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
      set = 1'b0; wr_addr = '0; in = '0; rsp_ready = 1'b1;
      for (int unsigned i = 0; i < 32; i++) wr(5'(i), $urandom);
      step();
      reset = 1'b0;
      step();

      // Basic fetch with read-port sequencing
      wr(5'd3, 32'h11111111);
      wr(5'd7, 32'h22222222);
      issue(5'd3, 5'd7);
      chk("dir_addr_a", {27'd0, arr_addr}, 32'd3);
      step();
      chk("dir_addr_b", {27'd0, arr_addr}, 32'd7);
      step();
      chk("dir_valid", {31'd0, rsp_valid}, 32'd1);
      chk("dir_out_a", out_a, 32'h11111111);
      chk("dir_out_b", out_b, 32'h22222222);
      step();

      // r0 always reads zero
      wr(5'd0, 32'hDEADBEEF);
      issue(5'd0, 5'd0);
      step(); step();
      chk("zero_out_a", out_a, 32'd0);
      chk("zero_out_b", out_b, 32'd0);
      step();

      // Same index twice with a write forwarded during READ_A
      wr(5'd5, 32'hAAAA0000);
      issue(5'd5, 5'd5);
      set = 1'b1; wr_addr = 5'd5; in = 32'h0000BBBB;
      step();
      set = 1'b0;
      step();
      chk("fwd_out_a", out_a, 32'h0000BBBB);
      chk("fwd_out_b", out_b, 32'h0000BBBB);
      step();

      // Held response tracks writes; handshake-cycle write is ignored
      rsp_ready = 1'b0;
      issue(5'd3, 5'd7);
      step(); step();
      step();
      set = 1'b1; wr_addr = 5'd3; in = 32'h33333333;
      step();
      set = 1'b0;
      chk("held_out_a", out_a, 32'h33333333);
      step(); step();
      step();
      rsp_ready = 1'b1; set = 1'b1; wr_addr = 5'd3; in = 32'h44444444;
      step();
      set = 1'b0;
      chk("hs_req_ready", {31'd0, req_ready}, 32'd1);
      chk("hs_out_a", out_a, 32'h33333333);

      // Reset during READ_B discards the request
      issue(5'd3, 5'd7);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_out_a", out_a, 32'd0);
      chk("rst_out_b", out_b, 32'd0);
      for (int unsigned i = 0; i < 5; i++) step();

      // Randomized traffic, small index range to provoke collisions
      for (int unsigned i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 99) == 0);
         req_valid = $urandom_range(0, 1) == 1;
         req_a     = 5'($urandom_range(0, 7));
         req_b     = 5'($urandom_range(0, 7));
         set       = $urandom_range(0, 1) == 1;
         wr_addr   = 5'($urandom_range(0, 7));
         in        = $urandom;
         rsp_ready = $urandom_range(0, 2) != 0;
         step();
      end

      reset = 1'b0; req_valid = 1'b0; set = 1'b0; rsp_ready = 1'b1;
      for (int unsigned i = 0; i < 6; i++) step();
      chk("drain_pending", 32'(pend.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
